// File: rtl/mp_pkg.sv
// rtl/mp_pkg.sv - shared constants, FSM encoding and helpers for the vectored interrupt controller
package mp_pkg;

    localparam int NUM_IRQ = 4;
    localparam int IDX_W   = 2;

    // Handler placement in instruction memory; the core uses the same value.
    localparam logic [3:0] DEFAULT_VEC_BASE = 4'd12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_IRQ-1:0] one;
        one = '0;
        one[idx] = 1'b1;
        return one;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchroniser, history flop and rising-edge pulse for one line
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1, s2, s3;
    logic f1, f2;
    logic armed;

    // Synchronise, keep history, and arm only after the line has been seen low
    // on a real (post-reset) sample so lines already high at release stay silent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            f1    <= 1'b0;
            f2    <= 1'b0;
            armed <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            s3    <= s2;
            f1    <= 1'b1;
            f2    <= f1;
            armed <= armed | (f2 & ~s2);
        end
    end

    assign rise = s2 & ~s3 & armed;

endmodule

// File: rtl/vec_int_ctrl.sv
// rtl/vec_int_ctrl.sv - vectored interrupt controller: pending/mask, priority select, handshake FSM
module vec_int_ctrl
    import mp_pkg::*;
#(
    parameter logic [3:0] VEC_BASE = DEFAULT_VEC_BASE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_in,
    input  logic               inta,
    input  logic               eoi,
    output logic               intr,
    output logic [3:0]         vector,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [NUM_IRQ-1:0] mask,
    output logic               busy
);

    state_t               state, state_nxt;
    logic [NUM_IRQ-1:0]   rise;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   mask_nxt;
    logic [NUM_IRQ-1:0]   clr;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     win_idx;
    logic                 req_any;
    logic                 accept;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_sync_edge u_sync (
            .clk  (clk),
            .rst  (rst),
            .din  (irq_in[g]),
            .rise (rise[g])
        );
    end

    assign eligible = pending & ~mask;
    assign req_any  = |eligible;
    // A same-edge mask write already counts against the request being held.
    assign mask_nxt = mask_we ? mask_in : mask;
    assign clr      = accept ? onehot(sel_idx) : '0;
    assign busy     = (state != IDLE);

    // Fixed priority: lowest index wins.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = i[IDX_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and acceptance decode; inta beats a same-edge masking write.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE:    if (req_any) state_nxt = REQ;
            REQ: begin
                if (inta) begin
                    state_nxt = SERVICE;
                    accept    = 1'b1;
                end else if (mask_nxt[sel_idx] || !pending[sel_idx]) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: if (eoi) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pending, mask, in-service and registered request/vector outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending    <= '0;
            mask       <= '0;
            in_service <= '0;
            intr       <= 1'b0;
            vector     <= '0;
            sel_idx    <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
            if (mask_we) mask <= mask_in;
            if (accept) in_service <= onehot(sel_idx);
            else if (state == SERVICE && eoi) in_service <= '0;
            intr <= (state_nxt == REQ);
            if (state == IDLE && req_any) begin
                sel_idx <= win_idx;
                vector  <= VEC_BASE + {2'b00, win_idx};
            end
        end
    end

endmodule

// File: tb/tb_vec_int_ctrl.sv
// tb/tb_vec_int_ctrl.sv - directed self-checking bench for vec_int_ctrl
module tb_vec_int_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       inta;
    logic       eoi;
    logic       intr;
    logic [3:0] vector;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic [3:0] mask;
    logic       busy;

    int checks = 0;
    int errors = 0;

    vec_int_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .inta       (inta),
        .eoi        (eoi),
        .intr       (intr),
        .vector     (vector),
        .pending    (pending),
        .in_service (in_service),
        .mask       (mask),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b0;
        irq_in  = 4'hF;
        mask_we = 1'b0;
        mask_in = 4'h0;
        inta    = 1'b0;
        eoi     = 1'b0;

        // Reset with all lines high
        steps(3);
        chk("rst_intr", {7'd0, intr}, 8'd0);
        chk("rst_pending", {4'd0, pending}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_vector", {4'd0, vector}, 8'd0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("held_pending", {4'd0, pending}, 8'd0);
            chk("held_intr", {7'd0, intr}, 8'd0);
            chk("held_mask", {4'd0, mask}, 8'd0);
        end

        // Single request on line 2
        irq_in = 4'h0;
        steps(3);
        irq_in = 4'b0100;
        steps(2);
        chk("single_pend_e2", {4'd0, pending}, 8'h0);
        step();
        chk("single_pend_e3", {4'd0, pending}, 8'h4);
        chk("single_intr_e3", {7'd0, intr}, 8'd0);
        step();
        chk("single_intr", {7'd0, intr}, 8'd1);
        chk("single_vector", {4'd0, vector}, 8'd14);
        chk("single_busy", {7'd0, busy}, 8'd1);
        inta = 1'b1; step(); inta = 1'b0;
        chk("single_ack_pend", {4'd0, pending}, 8'h0);
        chk("single_ack_isr", {4'd0, in_service}, 8'h4);
        chk("single_ack_intr", {7'd0, intr}, 8'd0);
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("single_eoi_isr", {4'd0, in_service}, 8'h0);
        chk("single_eoi_busy", {7'd0, busy}, 8'd0);

        // Priority: lines 3 and 1 together
        irq_in = 4'b1110;
        steps(3);
        chk("prio_pend", {4'd0, pending}, 8'hA);
        step();
        chk("prio_intr", {7'd0, intr}, 8'd1);
        chk("prio_vector", {4'd0, vector}, 8'd13);
        inta = 1'b1; step(); inta = 1'b0;
        chk("prio_isr", {4'd0, in_service}, 8'h2);
        chk("prio_pend_left", {4'd0, pending}, 8'h8);
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("prio_eoi_intr", {7'd0, intr}, 8'd0);
        chk("prio_eoi_busy", {7'd0, busy}, 8'd0);
        step();
        chk("prio_second_intr", {7'd0, intr}, 8'd1);
        chk("prio_second_vector", {4'd0, vector}, 8'd15);
        inta = 1'b1; step(); inta = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;

        // Latched vector
        irq_in = 4'h0;
        steps(3);
        irq_in = 4'b0100;
        steps(4);
        chk("latch_vector_a", {4'd0, vector}, 8'd14);
        irq_in = 4'b0101;
        steps(3);
        chk("latch_pend", {4'd0, pending}, 8'h5);
        chk("latch_vector_b", {4'd0, vector}, 8'd14);
        chk("latch_intr", {7'd0, intr}, 8'd1);
        inta = 1'b1; step(); inta = 1'b0;
        chk("latch_isr", {4'd0, in_service}, 8'h4);
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
        chk("latch_next_vector", {4'd0, vector}, 8'd12);
        chk("latch_next_intr", {7'd0, intr}, 8'd1);
        inta = 1'b1; step(); inta = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;

        // Mask withdrawal
        irq_in = 4'h0;
        steps(3);
        irq_in = 4'b0010;
        steps(4);
        chk("mask_req_intr", {7'd0, intr}, 8'd1);
        mask_we = 1'b1; mask_in = 4'b0010; step(); mask_we = 1'b0;
        chk("mask_drop_intr", {7'd0, intr}, 8'd0);
        chk("mask_keep_pend", {4'd0, pending}, 8'h2);
        chk("mask_reg", {4'd0, mask}, 8'h2);
        chk("mask_busy", {7'd0, busy}, 8'd0);
        step();
        chk("mask_still_low", {7'd0, intr}, 8'd0);
        mask_we = 1'b1; mask_in = 4'b0000; step(); mask_we = 1'b0;
        chk("unmask_reg", {4'd0, mask}, 8'h0);
        step();
        chk("unmask_intr", {7'd0, intr}, 8'd1);
        chk("unmask_vector", {4'd0, vector}, 8'd13);
        inta = 1'b1; step(); inta = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;

        // Reset in the middle of SERVICE
        irq_in = 4'h0;
        steps(3);
        irq_in = 4'b0001;
        steps(4);
        chk("mid_vector", {4'd0, vector}, 8'd12);
        inta = 1'b1; step(); inta = 1'b0;
        irq_in = 4'b1001;
        steps(3);
        chk("mid_isr", {4'd0, in_service}, 8'h1);
        chk("mid_pend", {4'd0, pending}, 8'h8);
        #2 rst = 1'b0;
        #1;
        chk("async_intr", {7'd0, intr}, 8'd0);
        chk("async_pend", {4'd0, pending}, 8'h0);
        chk("async_isr", {4'd0, in_service}, 8'h0);
        chk("async_busy", {7'd0, busy}, 8'd0);
        chk("async_vector", {4'd0, vector}, 8'd0);
        step();
        rst = 1'b1;
        steps(4);
        chk("post_busy", {7'd0, busy}, 8'd0);
        chk("post_intr", {7'd0, intr}, 8'd0);
        chk("post_pend", {4'd0, pending}, 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_int_ctrl.md
Name: vec_int_ctrl

Overview:
- Vectored interrupt controller that sits directly upstream of the processor core.
- Synchronises four external interrupt lines, rising-edge detects them and latches them as pending.
- Selects the highest-priority unmasked request and presents a 4-bit vector address, which the core loads into its 4-bit PC.
- Tracks the acknowledge / end-of-interrupt handshake with the core.

Parameters:
- NUM_IRQ, 4: number of interrupt lines. Fixed at 4 in this revision.
- VEC_BASE, 4'd12: instruction-memory address of the line-0 handler. Line n vectors to VEC_BASE+n.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- irq_in  in  4  raw interrupt lines, asynchronous to clk. Bit 0 has highest priority.
- mask_we  in  1  write strobe for the mask register.
- mask_in  in  4  new mask value; 1 = line masked.
- inta  in  1  interrupt acknowledge from the core. One-cycle pulse.
- eoi  in  1  end-of-interrupt from the core. One-cycle pulse.
- intr  out  1  interrupt request to the core.
- vector  out  4  handler address. Valid while intr=1.
- pending  out  4  latched pending bits.
- in_service  out  4  one-hot line currently being serviced; 0 when none.
- mask  out  4  current mask register.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous): intr=0, vector=0, pending=0, in_service=0, mask=0 (all lines enabled), busy=0, FSM=IDLE.
  - Synchroniser and edge-detect flops also clear to 0.
  - Reset mid-handshake abandons it; no state survives.
- Input path, per line:
  - Two-flop synchroniser (s1, s2), then a history flop s3.
  - Edge = s2 & ~s3.
  - A pending bit sets on the clock edge following edge detection. If irq_in rises before clock edge E1, pending is visible after edge E3.
  - Level-held lines produce exactly one pending event per rising edge.
- Mask:
  - mask_we=1 loads mask_in at the clock edge, in any state.
  - Masked lines still set pending; they are not eligible for selection.
- FSM IDLE -> REQ:
  - Condition: any (pending & ~mask) bit set.
  - Fixed priority: lowest index wins.
  - On that edge, latch sel_idx and drive vector=VEC_BASE+sel_idx (4-bit wrap-around).
  - intr=1 is registered and asserted the cycle after the transition.
- REQ:
  - intr=1; vector held stable.
  - A higher-priority line becoming pending does NOT change the vector.
  - inta=1 -> SERVICE on that edge: pending[sel_idx] clears, in_service[sel_idx] sets, intr=0 from the next cycle.
  - Masking sel_idx before inta, or having it unmasked-check fail, -> IDLE: intr drops next cycle, pending bit retained. If both inta and a masking write occur on the same edge, inta wins.
- SERVICE:
  - intr=0, busy=1. No nesting; new requests stay pending.
  - eoi=1 -> IDLE: in_service clears to 0.
  - The earliest next intr is asserted 2 cycles after eoi.
- Ignored inputs: inta outside REQ and eoi outside SERVICE have no effect.
- Simultaneous events: if a new edge on line n occurs on the same edge that clears pending[n] (acceptance), set wins and pending[n] remains 1.
- Widths: vector addition is modulo 16. No other arithmetic.

Decomposition:
- Shared package (mp_pkg):
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2).
  - NUM_IRQ and the default VEC_BASE.
  - The core also uses VEC_BASE to place handlers.
- Sub-module irq_sync_edge:
  - One instance per line, with clk and rst ports.
  - Contains the two-flop synchroniser plus history flop.
  - Outputs a one-cycle edge pulse.
- Top level: pending/mask registers, priority encoder, FSM and output registers.

Test Plan:
- Reset: hold rst=0 with irq_in=4'hF, release, hold irq_in steady high -> pending=0, intr=0, mask=0 throughout; no event is generated from lines already high at release. Only a new rising edge produces an event.
- Single request: irq_in[2] 0->1 -> pending=4'b0100 after 3rd edge, intr=1 with vector=4'd14 one cycle later. Then inta pulse -> pending=0, in_service=4'b0100, intr=0. Then eoi -> in_service=0, busy=0.
- Priority: irq_in[3] and irq_in[1] rise same cycle -> vector=4'd13. After eoi, second request with vector=4'd15; intr re-asserts 2 cycles after eoi.
- Latched vector: line 2 in REQ, then irq_in[0] rises before inta -> vector stays 14. After line 2's eoi, next vector=12.
- Mask withdrawal: in REQ for line 1, write mask=4'b0010 -> intr=0 next cycle, pending[1]=1 retained. Write mask=0 -> intr reasserts, vector=13.
- Reset mid-SERVICE: rst low while in_service=4'b0001 and pending=4'b1000 -> all outputs 0 immediately, asynchronously; after release the FSM is in IDLE.
